riscv_muldiv_unit: RTL and testbench
====================================

// Module: riscv_muldiv_unit
// PURPOSE
//  Parametrised iterative RV32M multiply/divide unit for the next-generation core: executes
//  MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU beside the single-cycle ALU. The datapath issues
//  operands with a start pulse, stalls on busy and writes back result on the done pulse.
//  Radix-2: one partial product / quotient bit per cycle; special cases finish early.
// PARAMETERS
//  WIDTH     32  operand/result width (>=8, even)
//  FAST_MUL  0   1: all MUL* complete in 1 cycle via combinational multiplier; 0: iterative
// PORTS
//  clk      in   1      rising-edge clock
//  reset_n  in   1      asynchronous active-low reset
//  start    in   1      launch op; accepted only when busy=0
//  funct3   in   3      RV32M op select (instr[14:12])
//  a        in   WIDTH  rs1 operand
//  b        in   WIDTH  rs2 operand
//  kill     in   1      abort in-flight op (pipeline flush)
//  busy     out  1      op in flight; start ignored while high
//  done     out  1      1-cycle pulse, result valid this cycle
//  result   out  WIDTH  op result; held until next accepted start
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE, busy=0, done=0, result=0, counter=0; mid-op reset
//   discards the op, no done.
//  Accept cycle C: start=1 & busy=0 & kill=0 -> latch funct3,a,b; busy=1 from C+1.
//  FSM: IDLE -> CALC (WIDTH cycles, counter WIDTH-1..0) -> FIXUP (1 cycle) -> DONE (1 cycle,
//   done=1, busy=0) -> IDLE. DONE accepts a new start (back-to-back issue).
//  Latency: done asserted in cycle C+WIDTH+2 for iterative ops.
//  Early-out (IDLE -> DONE directly, done in C+1): DIV/DIVU/REM/REMU with b=0;
//   DIV/REM with a=MIN_INT & b=-1; all MUL* when FAST_MUL=1.
//  Signedness: MULH/DIV/REM signed x signed; MULHSU signed a x unsigned b; rest unsigned.
//   Iterate on magnitudes; FIXUP applies 2's-complement negation to product/quotient/remainder.
//  MUL: low WIDTH bits of 2*WIDTH product; MULH*: high WIDTH bits.
//  Div-by-zero: quotient = all ones, remainder = a (unsigned and signed).
//  Overflow: MIN_INT/-1 -> quotient MIN_INT, remainder 0.
//  Signed rounding: quotient truncates toward zero; remainder takes sign of dividend.
//  kill=1 in any cycle: next state IDLE, busy=0, no done, result unchanged; kill wins over a
//   simultaneous start. kill in IDLE: no effect.
//  start while busy=1 (CALC/FIXUP): ignored, no error, no queuing.
//  Counter is $clog2(WIDTH) bits; terminates at 0 (no wrap).
// STRUCTURE
//  Package riscv_m_pkg: funct3 enum (MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100,
//   DIVU=101, REM=110, REMU=111), FSM state enum {IDLE,CALC,FIXUP,DONE}, op-class helpers
//   (is_div, a_signed, b_signed).
//  One sub-module: muldiv_step -- combinational single radix-2 iteration (shift-add for
//   multiply, restore-subtract for divide) on {hi,lo} accumulator; FSM/registers in top.
// TESTING (WIDTH=32, FAST_MUL=0 unless stated)
//  MUL a=7 b=0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 34 cycles after accept, busy
//   high cycles C+1..C+33.
//  MULH a=b=0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE;
//   MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
//  DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
//  DIVU 0x1234/0 -> 0xFFFFFFFF, REMU 0x1234/0 -> 0x1234, DIV 0x80000000/0xFFFFFFFF ->
//   0x80000000, REM -> 0; each done in C+1.
//  kill at C+10 of a DIV -> busy=0 at C+11, no done, result keeps prior value; start
//   asserted C+5 of an op ignored; reset_n low at C+15 -> all outputs 0 immediately.
//  FAST_MUL=1: MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE in C+1; back-to-back starts in
//   DONE cycles accepted, 100 random ops checked against reference model.

Source files
------------

// File: rtl/riscv_m_pkg.sv
// Package: riscv_m_pkg
// Shared definitions for the RV32M multiply/divide unit: the funct3 operation
// encoding, the sequencer state encoding and small op-class helpers that decide
// which operands are treated as two's-complement.
package riscv_m_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Divide/remainder ops all have funct3[2] set.
  function automatic logic is_div(input logic [2:0] f);
    return f[2];
  endfunction

  // rs1 is two's-complement for MULH, MULHSU, DIV and REM.
  function automatic logic a_signed(input logic [2:0] f);
    return (f == MULH) || (f == MULHSU) || (f == DIV) || (f == REM);
  endfunction

  // rs2 is two's-complement for MULH, DIV and REM (MULHSU treats it as unsigned).
  function automatic logic b_signed(input logic [2:0] f);
    return (f == MULH) || (f == DIV) || (f == REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// Module: muldiv_step
// One radix-2 iteration on a {hi,lo} accumulator, purely combinational.
//   is_div   : 1 = restoring divide step, 0 = shift-add multiply step
//   hi, lo   : accumulator (multiply: partial product / multiplier,
//              divide: partial remainder / dividend-becoming-quotient)
//   m        : multiplicand (multiply) or divisor (divide), both magnitudes
//   hi_next, lo_next : accumulator after this iteration
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] diff;

  // Multiply: add the multiplicand when the current multiplier LSB is set, then
  // shift the whole {carry,hi,lo} right so the next multiplier bit reaches lo[0].
  // Divide: shift the next dividend bit into the remainder and keep the
  // subtraction only when it does not borrow (diff[WIDTH] is the borrow since the
  // partial remainder is always below 2*m).
  always_comb begin
    add_sum   = {1'b0, hi} + {1'b0, m};
    rem_shift = {hi, lo[WIDTH-1]};
    diff      = rem_shift - {1'b0, m};
    hi_next   = hi;
    lo_next   = lo;
    if (is_div) begin
      if (!diff[WIDTH]) begin
        hi_next = diff[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = rem_shift[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (lo[0]) begin
        {hi_next, lo_next} = {add_sum, lo[WIDTH-1:1]};
      end else begin
        {hi_next, lo_next} = {1'b0, hi, lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/riscv_muldiv_unit.sv
// Module: riscv_muldiv_unit
// Iterative RV32M multiply/divide unit sitting beside the single-cycle ALU.
// Works on operand magnitudes one bit per cycle and negates the result in a
// final fixup cycle. Divide special cases (and all multiplies when FAST_MUL=1)
// bypass the iteration and finish the cycle after acceptance.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : launch an op (accepted in IDLE or DONE, when kill is low)
//   funct3       : RV32M op select
//   a, b         : rs1 / rs2 operands
//   kill         : abort the op in flight, no done is produced
//   busy         : op in flight (CALC/FIXUP)
//   done         : one-cycle pulse, result valid
//   result       : last completed result, held until replaced
module riscv_muldiv_unit
  import riscv_m_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int               CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state, state_n;
  logic [CW-1:0]    counter;
  logic [2:0]       op;
  logic             neg_res;
  logic [WIDTH-1:0] hi, lo, m;
  logic [WIDTH-1:0] hi_step, lo_step;
  logic [WIDTH-1:0] result_q;

  logic               accept;
  logic               a_neg, b_neg;
  logic               div_zero, div_ovf, early;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] fast_mag, fast_prod;
  logic [WIDTH-1:0]   early_result;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_rem, quo_rem_fix;
  logic [WIDTH-1:0]   fix_result;

  assign busy   = (state == CALC) || (state == FIXUP);
  assign done   = (state == DONE);
  assign result = result_q;
  assign accept = start && !kill && ((state == IDLE) || (state == DONE));

  // Operand decode for the op being offered this cycle: magnitudes for the
  // iteration, and the results of the paths that skip it entirely.
  always_comb begin
    a_neg    = a_signed(funct3) && a[WIDTH-1];
    b_neg    = b_signed(funct3) && b[WIDTH-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    div_zero = is_div(funct3) && (b == '0);
    div_ovf  = is_div(funct3) && !funct3[0] && (a == MIN_INT) && (b == '1);
    early    = div_zero || div_ovf || (FAST_MUL && !is_div(funct3));
    fast_mag  = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
    fast_prod = (a_neg ^ b_neg) ? -fast_mag : fast_mag;
    if (div_zero) begin
      early_result = funct3[1] ? a : '1;
    end else if (div_ovf) begin
      early_result = funct3[1] ? '0 : MIN_INT;
    end else if (funct3 == MUL) begin
      early_result = fast_prod[WIDTH-1:0];
    end else begin
      early_result = fast_prod[2*WIDTH-1:WIDTH];
    end
  end

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .is_div (is_div(op)),
    .hi     (hi),
    .lo     (lo),
    .m      (m),
    .hi_next(hi_step),
    .lo_next(lo_step)
  );

  // Sign correction applied in FIXUP; op[1] selects remainder among divide ops.
  always_comb begin
    prod_fix    = neg_res ? -{hi, lo} : {hi, lo};
    quo_rem     = op[1] ? hi : lo;
    quo_rem_fix = neg_res ? -quo_rem : quo_rem;
    if (is_div(op)) begin
      fix_result = quo_rem_fix;
    end else if (op == MUL) begin
      fix_result = prod_fix[WIDTH-1:0];
    end else begin
      fix_result = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; kill overrides everything, including a same-cycle start.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = early ? DONE : CALC;
      CALC:    if (counter == '0) state_n = FIXUP;
      FIXUP:   state_n = DONE;
      DONE:    state_n = accept ? (early ? DONE : CALC) : IDLE;
      default: state_n = IDLE;
    endcase
    if (kill) state_n = IDLE;
  end

  // Datapath registers. The result register only changes on completion, so a
  // killed op leaves the previous result visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter  <= '0;
      op       <= '0;
      neg_res  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      m        <= '0;
      result_q <= '0;
    end else if (accept) begin
      op       <= funct3;
      neg_res  <= (is_div(funct3) && funct3[1]) ? a_neg : (a_neg ^ b_neg);
      hi       <= '0;
      lo       <= is_div(funct3) ? a_mag : b_mag;
      m        <= is_div(funct3) ? b_mag : a_mag;
      counter  <= CNT_LAST;
      if (early) result_q <= early_result;
    end else if (!kill && state == CALC) begin
      hi <= hi_step;
      lo <= lo_step;
      if (counter != '0) counter <= counter - 1'b1;
    end else if (!kill && state == FIXUP) begin
      result_q <= fix_result;
    end
  end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Testbench: tb_riscv_muldiv_unit
// Directed and model-checked stimulus for an iterative instance (FAST_MUL=0)
// and a single-cycle-multiply instance (FAST_MUL=1) of riscv_muldiv_unit.
// Inputs are driven on the falling edge and outputs sampled on the falling edge.
module tb_riscv_muldiv_unit;
  import riscv_m_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, kill;
  logic [2:0]  funct3;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;
  logic        f_start, f_kill;
  logic [2:0]  f_funct3;
  logic [31:0] f_a, f_b;
  logic        f_busy, f_done;
  logic [31:0] f_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_muldiv_unit #(.WIDTH(32), .FAST_MUL(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .funct3(funct3), .a(a), .b(b),
    .kill(kill), .busy(busy), .done(done), .result(result)
  );

  riscv_muldiv_unit #(.WIDTH(32), .FAST_MUL(1'b1)) dut_fast (
    .clk(clk), .reset_n(reset_n), .start(f_start), .funct3(f_funct3), .a(f_a), .b(f_b),
    .kill(f_kill), .busy(f_busy), .done(f_done), .result(f_result)
  );

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] sx, zx, sy, zy, p;
    logic        ovf;
    sx  = {{32{x[31]}}, x};
    zx  = {32'b0, x};
    sy  = {{32{y[31]}}, y};
    zy  = {32'b0, y};
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    p   = 64'd0;
    case (f)
      3'b000: begin p = zx * zy; return p[31:0]; end
      3'b001: begin p = sx * sy; return p[63:32]; end
      3'b010: begin p = sx * zy; return p[63:32]; end
      3'b011: begin p = zx * zy; return p[63:32]; end
      3'b100: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'($signed(x) / $signed(y));
      end
      3'b101: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'b110: begin
        if (y == 0) return x;
        if (ovf) return 32'd0;
        return 32'($signed(x) % $signed(y));
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    if (f[2] && (y == 0)) return 1;
    if (f[2] && !f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Drive a start for one cycle from the current falling edge; returns in C+1.
  task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    start  = 1'b1;
    funct3 = f;
    a      = x;
    b      = y;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Count cycles from C+k0 until done, with a bounded budget.
  task automatic wait_done(input int k0, output logic [31:0] res, output int lat, output bit busy_ok);
    int k;
    k       = k0;
    lat     = -1;
    res     = '0;
    busy_ok = 1'b1;
    while (k <= 60) begin
      if (done === 1'b1) begin
        lat = k;
        res = result;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0; kill = 1'b0; funct3 = '0; a = '0; b = '0;
    f_start = 1'b0; f_kill = 1'b0; f_funct3 = '0; f_a = '0; f_b = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++;
    if (result !== 32'd0) begin errors++; $display("[TB] FAIL reset_result: got %h expected 0", result); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [31:0] res;
    int          lat;
    bit          bok;
    issue(3'b000, 32'd7, 32'hFFFF_FFFD);
    wait_done(1, res, lat, bok);
    checks++;
    if (res !== 32'hFFFF_FFEB) begin errors++; $display("[TB] FAIL mul_result: got %h expected ffffffeb", res); end
    checks++;
    if (lat !== 34) begin errors++; $display("[TB] FAIL mul_latency: got %0d expected 34", lat); end
    checks++;
    if (bok !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL mul_busy: busy_window %b done_busy %b expected 1 0", bok, busy); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL mul_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_mulh();
    logic [2:0]  fv [3] = '{3'b001, 3'b011, 3'b010};
    logic [31:0] xv [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] yv [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd2};
    logic [31:0] ev [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [31:0] res;
    int          lat;
    bit          bok;
    for (int i = 0; i < 3; i++) begin
      issue(fv[i], xv[i], yv[i]);
      wait_done(1, res, lat, bok);
      checks++;
      if (res !== ev[i] || lat !== 34) begin
        errors++;
        $display("[TB] FAIL mulh_%0d: got %h lat %0d expected %h lat 34", i, res, lat, ev[i]);
      end
    end
    @(negedge clk);
  endtask

  // Ops issued back-to-back in the DONE cycle of the previous one.
  task automatic test_div();
    logic [2:0]  fv [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] xv [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] yv [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] ev [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    logic [31:0] res;
    int          lat;
    bit          bok;
    for (int i = 0; i < 4; i++) begin
      issue(fv[i], xv[i], yv[i]);
      wait_done(1, res, lat, bok);
      checks++;
      if (res !== ev[i] || lat !== 34 || bok !== 1'b1) begin
        errors++;
        $display("[TB] FAIL div_%0d: got %h lat %0d busy %b expected %h lat 34 busy 1", i, res, lat, bok, ev[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_special();
    logic [2:0]  fv [6] = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110};
    logic [31:0] xv [6] = '{32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [31:0] yv [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] ev [6] = '{32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    logic [31:0] res;
    int          lat;
    bit          bok;
    for (int i = 0; i < 6; i++) begin
      issue(fv[i], xv[i], yv[i]);
      wait_done(1, res, lat, bok);
      checks++;
      if (res !== ev[i] || lat !== 1) begin
        errors++;
        $display("[TB] FAIL special_%0d: got %h lat %0d expected %h lat 1", i, res, lat, ev[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL special_idle: done %b busy %b expected 0 0", done, busy); end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] res;
    int          lat;
    bit          bok;
    issue(3'b101, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; funct3 = 3'b000; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, res, lat, bok);
    checks++;
    if (res !== 32'd14 || lat !== 34 || bok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_start: got %h lat %0d busy %b expected 0000000e lat 34 busy 1", res, lat, bok);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_start_queued: done %b busy %b expected 0 0", done, busy); end
  endtask

  task automatic test_kill();
    int seen;
    issue(3'b100, 32'd100, 32'd3);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL kill_busy: busy %b done %b expected 0 0", busy, done); end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("[TB] FAIL kill_no_done: got %0d done pulses expected 0", seen); end
    checks++;
    if (result !== 32'd14) begin errors++; $display("[TB] FAIL kill_result: got %h expected 0000000e", result); end
    kill = 1'b1; start = 1'b1; funct3 = 3'b101; a = 32'd9; b = 32'd0;
    @(negedge clk);
    kill = 1'b0; start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== 32'd14) begin
      errors++;
      $display("[TB] FAIL kill_vs_start: done %b busy %b result %h expected 0 0 0000000e", done, busy, result);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    issue(3'b000, 32'd5, 32'd6);
    repeat (14) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid: busy %b done %b result %h expected 0 0 0", busy, done, result);
    end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0 || result !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_after: got %0d done pulses result %h expected 0 0", seen, result);
    end
  endtask

  task automatic test_random_iter();
    logic [2:0]  f;
    logic [31:0] x, y, res;
    int          lat;
    bit          bok;
    for (int i = 0; i < 24; i++) begin
      f = 3'($urandom_range(0, 7));
      x = (i % 5 == 4) ? 32'h8000_0000 : $urandom;
      case (i % 4)
        0: y = $urandom;
        1: y = 32'($urandom_range(0, 9));
        2: y = (i % 8 == 2) ? 32'd0 : 32'hFFFF_FFFF;
        default: y = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
      endcase
      issue(f, x, y);
      wait_done(1, res, lat, bok);
      checks++;
      if (res !== ref_op(f, x, y) || lat !== ref_lat(f, x, y)) begin
        errors++;
        $display("[TB] FAIL rand_%0d: f %0d a %h b %h got %h lat %0d expected %h lat %0d",
                 i, f, x, y, res, lat, ref_op(f, x, y), ref_lat(f, x, y));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_fast();
    logic [2:0]  f;
    logic [31:0] x, y, exp_prev;
    f_start = 1'b1; f_funct3 = 3'b011; f_a = 32'hFFFF_FFFF; f_b = 32'hFFFF_FFFF;
    @(negedge clk);
    f_start = 1'b0;
    checks++;
    if (f_done !== 1'b1 || f_result !== 32'hFFFF_FFFE || f_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fast_mulhu: done %b busy %b result %h expected 1 0 fffffffe", f_done, f_busy, f_result);
    end
    @(negedge clk);
    checks++;
    if (f_done !== 1'b0) begin errors++; $display("[TB] FAIL fast_done_pulse: got %b expected 0", f_done); end
    exp_prev = '0;
    for (int i = 0; i <= 100; i++) begin
      if (i > 0) begin
        checks++;
        if (f_done !== 1'b1 || f_result !== exp_prev) begin
          errors++;
          $display("[TB] FAIL fast_b2b_%0d: done %b result %h expected 1 %h", i - 1, f_done, f_result, exp_prev);
        end
      end
      if (i < 100) begin
        f = 3'($urandom_range(0, 3));
        x = $urandom;
        y = $urandom;
        f_start = 1'b1; f_funct3 = f; f_a = x; f_b = y;
        exp_prev = ref_op(f, x, y);
      end else begin
        f_start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_start_while_busy();
    test_kill();
    test_reset_mid();
    test_random_iter();
    test_fast();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
